// File: rtl/top_pipe_pkg.sv
// Shared definitions for the top_pipe evaluator: operand width, operand types
// and the issue-to-result latency.
package top_pipe_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int PIPE_LATENCY = 3;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        data_t a;
        data_t b;
        data_t c;
        data_t d;
    } operand_set_t;

endpackage

// File: rtl/top_pipe_hold.sv
// One operand hold slot: captures the newest valid value and remembers that it
// is pending until the set it belongs to issues.
module top_pipe_hold #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             valid,
    input  logic             issue,
    output logic [WIDTH-1:0] held_value,
    output logic             held
);

    // A valid on the issue edge is consumed directly by the issuing set, so
    // issue takes priority and leaves the slot empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_value <= '0;
            held       <= 1'b0;
        end else if (issue) begin
            held       <= 1'b0;
        end else if (valid) begin
            held_value <= value;
            held       <= 1'b1;
        end
    end

endmodule

// File: rtl/top_pipe.sv
// Pipelined evaluator q = floor(((a - b)*(1 + 3c) - 4d) / 2) with four
// independently validated operands. Define TOP_PIPE_OVF_FLAG_EN to add ovf_o.
module top_pipe
    import top_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = top_pipe_pkg::DATA_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         artsn_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic                         a_valid_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic                         b_valid_i,
    input  logic signed [DATA_WIDTH-1:0] c_i,
    input  logic                         c_valid_i,
    input  logic signed [DATA_WIDTH-1:0] d_i,
    input  logic                         d_valid_i,
    output logic signed [DATA_WIDTH-1:0] q_o,
    output logic                         q_valid_o
`ifdef TOP_PIPE_OVF_FLAG_EN
    ,
    output logic                         ovf_o
`endif
);

    typedef logic signed [DATA_WIDTH-1:0] word_t;

    // Operand slots in a, b, c, d order.
    logic [3:0]            vld;
    logic [DATA_WIDTH-1:0] in_val   [4];
    logic [DATA_WIDTH-1:0] held_val [4];
    logic [3:0]            held;
    word_t                 eff      [4];
    logic                  issue;

    assign vld       = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
    assign in_val[0] = a_i;
    assign in_val[1] = b_i;
    assign in_val[2] = c_i;
    assign in_val[3] = d_i;

    for (genvar i = 0; i < 4; i++) begin : g_hold
        top_pipe_hold #(.WIDTH(DATA_WIDTH)) u_hold (
            .clk        (clk_i),
            .rst        (artsn_i),
            .value      (in_val[i]),
            .valid      (vld[i]),
            .issue      (issue),
            .held_value (held_val[i]),
            .held       (held[i])
        );
    end

    // Same-cycle valids complete a set and also win over an older held value.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eff[i] = vld[i] ? word_t'(in_val[i]) : word_t'(held_val[i]);
        end
    end

    assign issue = &(held | vld);

    logic s1_v, s2_v, s3_v;

    always_ff @(posedge clk_i or posedge artsn_i) begin
        if (artsn_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= issue;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    word_t s_final;

`ifdef TOP_PIPE_OVF_FLAG_EN
    // Full-precision widths: difference, 1+3c, 4d, product and final sum.
    localparam int DW = DATA_WIDTH + 1;
    localparam int TW = DATA_WIDTH + 3;
    localparam int FW = DATA_WIDTH + 2;
    localparam int PW = DW + TW;
    localparam int SW = PW + 1;

    logic signed [DW-1:0] diff_n, s1_diff;
    logic signed [TW-1:0] t_n, s1_t;
    logic signed [FW-1:0] d4_n, s1_d4, s2_d4;
    logic signed [PW-1:0] s2_prod;
    logic signed [SW-1:0] s_n, s3_s;
    logic                 s1_ovf, s2_ovf, s3_ovf;

    function automatic logic fits(input logic signed [SW-1:0] v);
        word_t lo;
        lo = word_t'(v[DATA_WIDTH-1:0]);
        return v == SW'(lo);
    endfunction

    always_comb begin
        diff_n = DW'(eff[0]) - DW'(eff[1]);
        t_n    = TW'(eff[2]) + (TW'(eff[2]) <<< 1) + TW'(1);
        d4_n   = FW'(eff[3]) <<< 2;
        s_n    = SW'(s2_prod) - SW'(s2_d4);
    end

    assign s_final = word_t'(s3_s[DATA_WIDTH-1:0]);

    always_ff @(posedge clk_i or posedge artsn_i) begin
        if (artsn_i) begin
            s1_diff <= '0;
            s1_t    <= '0;
            s1_d4   <= '0;
            s1_ovf  <= 1'b0;
            s2_prod <= '0;
            s2_d4   <= '0;
            s2_ovf  <= 1'b0;
            s3_s    <= '0;
            s3_ovf  <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            s1_diff <= diff_n;
            s1_t    <= t_n;
            s1_d4   <= d4_n;
            s1_ovf  <= !fits(SW'(diff_n)) || !fits(SW'(t_n)) || !fits(SW'(d4_n));
            s2_prod <= PW'(s1_diff) * PW'(s1_t);
            s2_d4   <= s1_d4;
            s2_ovf  <= s1_ovf;
            s3_s    <= s_n;
            s3_ovf  <= s2_ovf || !fits(SW'(s2_prod)) || !fits(s_n);
            ovf_o   <= s3_v && s3_ovf;
        end
    end
`else
    word_t s1_diff, s1_t, s1_d4, s2_prod, s2_d4, s3_s;

    assign s_final = s3_s;

    always_ff @(posedge clk_i or posedge artsn_i) begin
        if (artsn_i) begin
            s1_diff <= '0;
            s1_t    <= '0;
            s1_d4   <= '0;
            s2_prod <= '0;
            s2_d4   <= '0;
            s3_s    <= '0;
        end else begin
            s1_diff <= eff[0] - eff[1];
            s1_t    <= word_t'(1) + eff[2] + (eff[2] <<< 1);
            s1_d4   <= eff[3] <<< 2;
            s2_prod <= s1_diff * s1_t;
            s2_d4   <= s1_d4;
            s3_s    <= s2_prod - s2_d4;
        end
    end
`endif

    // Result register only moves on a valid result so q_o holds in between.
    always_ff @(posedge clk_i or posedge artsn_i) begin
        if (artsn_i) begin
            q_o       <= '0;
            q_valid_o <= 1'b0;
        end else begin
            q_valid_o <= s3_v;
            if (s3_v) begin
                q_o <= s_final >>> 1;
            end
        end
    end

endmodule

// File: tb/tb_top_pipe.sv
// Directed self-checking bench for top_pipe: latency, staggered operands,
// overwrite, back-to-back streaming, mid-flight reset and wrap corners.
module tb_top_pipe;
    import top_pipe_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    data_t a = '0, b = '0, c = '0, d = '0;
    logic  av = 1'b0, bv = 1'b0, cv = 1'b0, dv = 1'b0;
    data_t q;
    logic  qv;
`ifdef TOP_PIPE_OVF_FLAG_EN
    logic  ovf;
    logic  exp_ovf_q[$];
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    data_t exp_q[$];
    data_t sa[$], sb[$], sc[$], sd[$];

    always #5 clk = ~clk;

    top_pipe dut (
        .clk_i     (clk),
        .artsn_i   (rst),
        .a_i       (a),
        .a_valid_i (av),
        .b_i       (b),
        .b_valid_i (bv),
        .c_i       (c),
        .c_valid_i (cv),
        .d_i       (d),
        .d_valid_i (dv),
        .q_o       (q),
        .q_valid_o (qv)
`ifdef TOP_PIPE_OVF_FLAG_EN
        ,
        .ovf_o     (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                      tag, $signed(got), got, $signed(exp), exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input data_t ia, input data_t ib,
                         input data_t ic, input data_t id);
        {dv, cv, bv, av} = v;
        a = ia; b = ib; c = ic; d = id;
    endtask

    task automatic idle();
        {dv, cv, bv, av} = 4'b0000;
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (qv === 1'b1) cnt++;
        end
    endtask

    function automatic data_t model_q(input data_t ma, input data_t mb,
                                      input data_t mc, input data_t md);
        data_t diff, t, p, s;
        diff = ma - mb;
        t    = data_t'(1) + data_t'(3) * mc;
        p    = diff * t;
        s    = p - data_t'(4) * md;
        return s >>> 1;
    endfunction

    function automatic logic fits32(input logic signed [127:0] v);
        data_t lo;
        lo = data_t'(v[31:0]);
        return v == 128'(lo);
    endfunction

    function automatic logic model_ovf(input data_t ma, input data_t mb,
                                       input data_t mc, input data_t md);
        logic signed [127:0] diff, t, d4, p, s;
        diff = 128'(ma) - 128'(mb);
        t    = 128'(1) + 128'(3) * 128'(mc);
        d4   = 128'(4) * 128'(md);
        p    = diff * t;
        s    = p - d4;
        return !fits32(diff) || !fits32(t) || !fits32(d4) || !fits32(p) || !fits32(s);
    endfunction

    // Full set on one edge, then watch the exact result cycle and the hold after it.
    task automatic run_one(input string tag, input data_t ia, input data_t ib,
                           input data_t ic, input data_t id, input data_t exp);
        drive(4'b1111, ia, ib, ic, id);
        tick();
        idle();
        tick();
        check({tag, "_early1"}, 32'(qv), 32'd0);
        tick();
        check({tag, "_early2"}, 32'(qv), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(qv), 32'd1);
        check({tag, "_q"}, q, exp);
        tick();
        check({tag, "_pulse_end"}, 32'(qv), 32'd0);
        check({tag, "_q_hold"}, q, exp);
    endtask

    task automatic run_stream(input string tag);
        int n;
        n = sa.size();
        for (int k = 0; k < n + PIPE_LATENCY; k++) begin
            if (k < n) begin
                drive(4'b1111, sa[k], sb[k], sc[k], sd[k]);
                exp_q.push_back(model_q(sa[k], sb[k], sc[k], sd[k]));
`ifdef TOP_PIPE_OVF_FLAG_EN
                exp_ovf_q.push_back(model_ovf(sa[k], sb[k], sc[k], sd[k]));
`endif
            end else begin
                idle();
            end
            tick();
            if (k >= PIPE_LATENCY) begin
                check({tag, "_valid"}, 32'(qv), 32'd1);
                check({tag, "_q"}, q, exp_q.pop_front());
`ifdef TOP_PIPE_OVF_FLAG_EN
                check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf_q.pop_front()));
`endif
            end
        end
        tick();
        check({tag, "_drain"}, 32'(qv), 32'd0);
        sa.delete(); sb.delete(); sc.delete(); sd.delete();
    endtask

    initial begin
        int cnt;
        data_t min_v;
        min_v = data_t'(32'h8000_0000);

        repeat (2) tick();
        check("rst_q", q, 32'd0);
        check("rst_qv", 32'(qv), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_qv", 32'(qv), 32'd0);

        // (10-4)*7 - 12 = 30 -> 15; (-1)*1 - 4 = -5 -> -3; (-3)*4 = -12 -> -6
        run_one("basic", 10, 4, 2, 3, 15);
        run_one("neg_floor", 0, 1, 0, 1, -3);
        run_one("neg_even", 1, 4, 1, 0, -6);

        // Staggered: a, then b, then c+d; issue on the third edge, result 3 -> 1.
        drive(4'b0001, 3, 99, 99, 99);
        tick();
        check("stag_none1", 32'(qv), 32'd0);
        drive(4'b0010, 99, 0, 99, 99);
        tick();
        check("stag_none2", 32'(qv), 32'd0);
        drive(4'b1100, 99, 99, 0, 0);
        tick();
        idle();
        tick();
        tick();
        check("stag_early", 32'(qv), 32'd0);
        tick();
        check("stag_valid", 32'(qv), 32'd1);
        check("stag_q", q, 1);
        count_pulses(6, cnt);
        check("stag_single", 32'(cnt), 32'd0);

        // Resent a: 5 then 7; with b=1 the set computes (7-1)=6 -> 3.
        drive(4'b0001, 5, 99, 99, 99);
        tick();
        drive(4'b0001, 7, 99, 99, 99);
        tick();
        drive(4'b1110, 99, 1, 0, 0);
        tick();
        idle();
        repeat (2) tick();
        tick();
        check("resend_valid", 32'(qv), 32'd1);
        check("resend_q", q, 3);

        // Held a=20 is overridden by a=8 on the issue edge: 8 -> 4.
        drive(4'b0001, 20, 99, 99, 99);
        tick();
        drive(4'b1111, 8, 0, 0, 0);
        tick();
        idle();
        repeat (2) tick();
        tick();
        check("issue_edge_q", q, 4);
        check("issue_edge_valid", 32'(qv), 32'd1);
        // No stale a may remain: b, c, d alone must not issue.
        drive(4'b1110, 99, 0, 0, 0);
        tick();
        idle();
        count_pulses(6, cnt);
        check("no_stale_a", 32'(cnt), 32'd0);

        // Ten back-to-back sets.
        for (int i = 0; i < 10; i++) begin
            sa.push_back(data_t'(i * 7 - 20));
            sb.push_back(data_t'(3 - i));
            sc.push_back(data_t'(i - 4));
            sd.push_back(data_t'(2 * i - 9));
        end
        run_stream("b2b");

        // Reset one cycle after an issue, with a/b/c also pending.
        drive(4'b1111, 10, 4, 2, 3);
        tick();
        drive(4'b0111, 1, 1, 1, 99);
        tick();
        rst = 1'b1;
        idle();
        tick();
        check("midrst_q", q, 32'd0);
        check("midrst_qv", 32'(qv), 32'd0);
        rst = 1'b0;
        tick();
        drive(4'b1000, 99, 99, 99, 5);
        tick();
        idle();
        count_pulses(6, cnt);
        check("midrst_no_pulse", 32'(cnt), 32'd0);
        check("midrst_q_after", q, 32'd0);
        // Reset cleared the pending d above? No: d was held after reset; clear it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Wrap corners, then random operands.
        sa.push_back(min_v); sb.push_back(1);     sc.push_back(0);     sd.push_back(0);
        sa.push_back(min_v); sb.push_back(0);     sc.push_back(0);     sd.push_back(0);
        sa.push_back(0);     sb.push_back(0);     sc.push_back(min_v); sd.push_back(0);
        sa.push_back(1);     sb.push_back(0);     sc.push_back(0);     sd.push_back(min_v);
        sa.push_back(-1);    sb.push_back(min_v); sc.push_back(-1);    sd.push_back(-1);
        for (int i = 0; i < 12; i++) begin
            sa.push_back(data_t'($urandom));
            sb.push_back(data_t'($urandom));
            sc.push_back(data_t'($urandom_range(0, 65535)) - data_t'(32768));
            sd.push_back(data_t'($urandom));
        end
        run_stream("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
